rom_bus_arbiter: RTL and testbench
==================================

Name: rom_bus_arbiter

Overview:
- Shares the single boot/program ROM between two requesters: port 0 (CPU instruction/data fetch) and port 1 (DMA/loader).
- Owns the ROM's chip-select and address lines and samples the ROM's read data.
- Applies round-robin arbitration and a configurable number of wait states.
- Returns registered read data with a one-cycle acknowledge to the granted requester.

Parameters:
- ADDR_WIDTH, 14, requester and ROM address width (16 KiB space).
- ROM_SIZE, 16384, number of populated ROM bytes; addresses >= ROM_SIZE are out of range.
- WAIT_STATES, 1, extra cycles rom_cs is held before data is sampled (0..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 (CPU) read request; held until ack0.
- addr0  in  ADDR_WIDTH  port 0 byte address; stable while req0 is high.
- ack0  out  1  one-cycle pulse: rdata valid for port 0.
- req1  in  1  port 1 (DMA) read request; held until ack1.
- addr1  in  ADDR_WIDTH  port 1 byte address; stable while req1 is high.
- ack1  out  1  one-cycle pulse: rdata valid for port 1.
- rdata  out  8  registered read data; valid only in an ack cycle.
- busy  out  1  high in every state except IDLE.
- grant  out  1  port currently or last served (0/1).
- rom_cs  out  1  ROM chip select.
- rom_addr  out  ADDR_WIDTH  ROM address.
- rom_data  in  8  ROM data; floats when rom_cs is low and must not be used then.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - rom_cs = 0, rom_addr = 0, ack0 = ack1 = 0, rdata = 8'h00, busy = 0.
  - grant = 1, so port 0 wins the first contention.
  - Reset asserted mid-access aborts the access immediately; no ack is issued for it.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req high: grant that port.
  - Both req high: grant the port that is NOT the current grant (round robin).
  - On grant, at the next edge: latch the address into rom_addr, update grant, load wait counter = WAIT_STATES, enter ACCESS.
  - rom_cs goes high on entry to ACCESS only if the latched address < ROM_SIZE; otherwise it stays 0.
- ACCESS:
  - rom_cs and rom_addr are held constant.
  - If counter != 0: decrement and stay in ACCESS.
  - If counter == 0: at this edge, capture rdata <= rom_data (or 8'hFF when out of range), drop rom_cs, assert ack of the grant port, enter DONE.
- DONE:
  - ackN is high for exactly this cycle; rdata is valid.
  - Next edge: ack low, go to IDLE.
  - rdata holds its value until the next capture.
- Latency: req sampled in IDLE at cycle 0; ACCESS occupies cycles 1..WAIT_STATES+1; ack at cycle WAIT_STATES+2; IDLE again at cycle WAIT_STATES+3.
- Requester rule: a requester deasserts req at the edge ending its ack cycle. A req still high when IDLE is reached is a new request.
- Requests arriving during ACCESS/DONE are queued by the held req. They are evaluated only in IDLE; nothing is dropped.
- Request changes:
  - Address changes while req is high and not yet granted are allowed.
  - After grant, the latched rom_addr is used and the addrN input is ignored.
- Simultaneous events: a req deasserted in the same cycle IDLE evaluates it is not granted. Both-request ties always alternate.
- ack0 and ack1 are never high together. rom_cs is never high outside ACCESS.
- Counter: 4 bits, no wrap; WAIT_STATES = 0 gives a single ACCESS cycle.

Test Plan:
- Single CPU read, WAIT_STATES=1: ROM[0x0000]=0x76, req0 with addr0=0x0000 at cycle 0 -> rom_cs high cycles 1-2, ack0 and rdata=0x76 at cycle 3, busy low at cycle 4.
- Contention: req0 (addr 0x0010, data 0x11) and req1 (addr 0x0020, data 0x22) both high from reset -> port 0 served first (ack0, rdata=0x11 at cycle 3), then port 1 (ack1, rdata=0x22 at cycle 7); ack0 and ack1 never overlap.
- Round robin under sustained load: both requesters re-request immediately for 6 transactions -> grant sequence 0,1,0,1,0,1.
- Out of range with ROM_SIZE=1: req1 at addr1=0x0005 -> rom_cs stays 0 throughout, ack1 with rdata=0xFF at cycle 3.
- Reset mid-access: assert reset in the first ACCESS cycle -> next cycle rom_cs=0, busy=0, no ack; a following req0 is granted to port 0 with normal latency.
- WAIT_STATES=0: req0 at addr 0x0003 (data 0xA5) -> rom_cs high only at cycle 1, ack0 and rdata=0xA5 at cycle 2.

Source files
------------

// File: rtl/rom_bus_arbiter.sv
// rom_bus_arbiter
// ---------------
// Shares one boot/program ROM between two read requesters. Port 0 is the
// CPU fetch port and port 1 is the DMA/loader port. The arbiter drives the
// ROM chip select and address, and it samples the ROM read data after a
// configurable number of wait states. It then returns registered data with
// a one-cycle acknowledge to the port that was granted. When both ports
// request in the same IDLE cycle, the grant alternates (round robin).
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset; aborts any access in flight
//   req0/1    read requests, held until the matching ack
//   addr0/1   byte addresses, sampled only in the cycle the port is granted
//   ack0/1    one-cycle pulse, rdata valid for that port
//   rdata     registered read data, holds until the next capture
//   busy      high whenever the FSM is not in IDLE
//   grant     port currently or last served
//   rom_cs    ROM chip select, only ever high during ACCESS
//   rom_addr  ROM address, latched at grant
//   rom_data  ROM read data, meaningful only while rom_cs is high
module rom_bus_arbiter #(
   parameter int ADDR_WIDTH  = 14,
   parameter int ROM_SIZE    = 16384,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   output logic                  ack0,
   input  logic                  req1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic                  ack1,
   output logic [7:0]            rdata,
   output logic                  busy,
   output logic                  grant,
   output logic                  rom_cs,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [7:0]            rom_data
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

   state_t                state_reg, state_next;
   logic                  grant_reg, grant_next;
   logic [3:0]            cnt_reg, cnt_next;
   logic [ADDR_WIDTH-1:0] rom_addr_reg, rom_addr_next;
   logic                  rom_cs_reg, rom_cs_next;
   logic                  oor_reg, oor_next;
   logic [7:0]            rdata_reg, rdata_next;
   logic                  ack0_reg, ack0_next;
   logic                  ack1_reg, ack1_next;

   logic                  pick;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic                  in_range;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         grant_reg    <= 1'b1;   // so port 0 wins the first tie
         cnt_reg      <= '0;
         rom_addr_reg <= '0;
         rom_cs_reg   <= 1'b0;
         oor_reg      <= 1'b0;
         rdata_reg    <= 8'h00;
         ack0_reg     <= 1'b0;
         ack1_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         grant_reg    <= grant_next;
         cnt_reg      <= cnt_next;
         rom_addr_reg <= rom_addr_next;
         rom_cs_reg   <= rom_cs_next;
         oor_reg      <= oor_next;
         rdata_reg    <= rdata_next;
         ack0_reg     <= ack0_next;
         ack1_reg     <= ack1_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      grant_next    = grant_reg;
      cnt_next      = cnt_reg;
      rom_addr_next = rom_addr_reg;
      rom_cs_next   = rom_cs_reg;
      oor_next      = oor_reg;
      rdata_next    = rdata_reg;
      ack0_next     = 1'b0;
      ack1_next     = 1'b0;

      // With both requests present, serve the port that did not go last.
      // Otherwise serve whichever single port is requesting.
      pick     = (req0 && req1) ? ~grant_reg : req1;
      sel_addr = pick ? addr1 : addr0;
      in_range = (32'(sel_addr) < 32'(ROM_SIZE));

      case (state_reg)
         IDLE: begin
            if (req0 || req1) begin
               rom_addr_next = sel_addr;
               grant_next    = pick;
               cnt_next      = WAIT_LOAD;
               // An out-of-range access runs the same timing, but the ROM is never selected.
               rom_cs_next   = in_range;
               oor_next      = ~in_range;
               state_next    = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
            end else begin
               rdata_next  = oor_reg ? 8'hFF : rom_data;
               rom_cs_next = 1'b0;
               ack0_next   = ~grant_reg;
               ack1_next   = grant_reg;
               state_next  = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next  = IDLE;
            rom_cs_next = 1'b0;
         end
      endcase
   end

   assign ack0     = ack0_reg;
   assign ack1     = ack1_reg;
   assign rdata    = rdata_reg;
   assign busy     = (state_reg != IDLE);
   assign grant    = grant_reg;
   assign rom_cs   = rom_cs_reg;
   assign rom_addr = rom_addr_reg;

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Testbench for rom_bus_arbiter. Three instances cover three cases:
// the default configuration (A), ROM_SIZE=1 for out-of-range reads (B),
// and WAIT_STATES=0 (C). Expected acks are pushed to a scoreboard when
// requests are driven. They are popped whenever any instance acknowledges.
module tb_rom_bus_arbiter;

   localparam int AW = 14;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
      case (a)
         14'h0000: rom_byte = 8'h76;
         14'h0003: rom_byte = 8'hA5;
         14'h0010: rom_byte = 8'h11;
         14'h0020: rom_byte = 8'h22;
         default:  rom_byte = a[7:0] ^ 8'h5A;
      endcase
   endfunction

   // Instance A: defaults
   logic a_req0 = 0, a_req1 = 0, a_ack0, a_ack1, a_busy, a_grant, a_rom_cs;
   logic [AW-1:0] a_addr0 = '0, a_addr1 = '0, a_rom_addr;
   logic [7:0] a_rdata, a_rom_data;
   assign a_rom_data = a_rom_cs ? rom_byte(a_rom_addr) : 8'hxx;

   // Instance B: ROM_SIZE = 1
   logic b_req0 = 0, b_req1 = 0, b_ack0, b_ack1, b_busy, b_grant, b_rom_cs;
   logic [AW-1:0] b_addr0 = '0, b_addr1 = '0, b_rom_addr;
   logic [7:0] b_rdata, b_rom_data;
   assign b_rom_data = b_rom_cs ? rom_byte(b_rom_addr) : 8'hxx;

   // Instance C: WAIT_STATES = 0
   logic c_req0 = 0, c_req1 = 0, c_ack0, c_ack1, c_busy, c_grant, c_rom_cs;
   logic [AW-1:0] c_addr0 = '0, c_addr1 = '0, c_rom_addr;
   logic [7:0] c_rdata, c_rom_data;
   assign c_rom_data = c_rom_cs ? rom_byte(c_rom_addr) : 8'hxx;

   rom_bus_arbiter #(.ADDR_WIDTH(AW), .ROM_SIZE(16384), .WAIT_STATES(1)) u_a (
      .clk(clk), .reset(reset),
      .req0(a_req0), .addr0(a_addr0), .ack0(a_ack0),
      .req1(a_req1), .addr1(a_addr1), .ack1(a_ack1),
      .rdata(a_rdata), .busy(a_busy), .grant(a_grant),
      .rom_cs(a_rom_cs), .rom_addr(a_rom_addr), .rom_data(a_rom_data));

   rom_bus_arbiter #(.ADDR_WIDTH(AW), .ROM_SIZE(1), .WAIT_STATES(1)) u_b (
      .clk(clk), .reset(reset),
      .req0(b_req0), .addr0(b_addr0), .ack0(b_ack0),
      .req1(b_req1), .addr1(b_addr1), .ack1(b_ack1),
      .rdata(b_rdata), .busy(b_busy), .grant(b_grant),
      .rom_cs(b_rom_cs), .rom_addr(b_rom_addr), .rom_data(b_rom_data));

   rom_bus_arbiter #(.ADDR_WIDTH(AW), .ROM_SIZE(16384), .WAIT_STATES(0)) u_c (
      .clk(clk), .reset(reset),
      .req0(c_req0), .addr0(c_addr0), .ack0(c_ack0),
      .req1(c_req1), .addr1(c_addr1), .ack1(c_ack1),
      .rdata(c_rdata), .busy(c_busy), .grant(c_grant),
      .rom_cs(c_rom_cs), .rom_addr(c_rom_addr), .rom_data(c_rom_data));

   typedef struct {
      int         inst;
      logic       port;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int inst, input logic port, input logic [7:0] data);
      exp_t e;
      e.inst = inst;
      e.port = port;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic sb_check(input int inst, input logic k0, input logic k1, input logic [7:0] rd);
      exp_t e;
      if (k0 || k1) begin
         chk("ack_exclusive", 32'(k0 & k1), 32'd0);
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected_ack observed=inst%0d expected=no_ack", inst);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_inst", 32'(inst), 32'(e.inst));
            chk("sb_port", 32'(k1), 32'(e.port));
            chk("sb_rdata", 32'(rd), 32'(e.data));
            $display("txn inst=%0d port=%0d rdata=%02h", inst, k1, rd);
         end
      end
   endtask

   task automatic observe();
      sb_check(0, a_ack0, a_ack1, a_rdata);
      sb_check(1, b_ack0, b_ack1, b_rdata);
      sb_check(2, c_ack0, c_ack1, c_rdata);
      chk("a_cs_only_busy", 32'(a_rom_cs & ~a_busy), 32'd0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      observe();
   endtask

   task automatic wait_a_ack(input int budget);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!(a_ack0 || a_ack1) && n < budget);
      if (!(a_ack0 || a_ack1)) chk("a_ack_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      // Reset state
      reset = 1'b1;
      step();
      step();
      chk("rst_cs", 32'(a_rom_cs), 32'd0);
      chk("rst_addr", 32'(a_rom_addr), 32'd0);
      chk("rst_ack", 32'({a_ack0, a_ack1}), 32'd0);
      chk("rst_rdata", 32'(a_rdata), 32'h00);
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_grant", 32'(a_grant), 32'd1);

      // Single CPU read, one wait state (cycle 0 is this cycle)
      reset = 1'b0;
      a_req0 = 1'b1;
      a_addr0 = 14'h0000;
      push(0, 1'b0, 8'h76);
      step();
      chk("t1_c1_cs", 32'(a_rom_cs), 32'd1);
      chk("t1_c1_busy", 32'(a_busy), 32'd1);
      chk("t1_c1_grant", 32'(a_grant), 32'd0);
      step();
      chk("t1_c2_cs", 32'(a_rom_cs), 32'd1);
      chk("t1_c2_ack", 32'(a_ack0), 32'd0);
      step();
      chk("t1_c3_ack0", 32'(a_ack0), 32'd1);
      chk("t1_c3_cs", 32'(a_rom_cs), 32'd0);
      a_req0 = 1'b0;
      step();
      chk("t1_c4_busy", 32'(a_busy), 32'd0);
      chk("t1_c4_ack0", 32'(a_ack0), 32'd0);
      chk("t1_c4_rdata_hold", 32'(a_rdata), 32'h76);

      // Contention starting from reset
      reset = 1'b1;
      a_req0 = 1'b1; a_addr0 = 14'h0010;
      a_req1 = 1'b1; a_addr1 = 14'h0020;
      step();
      reset = 1'b0;
      push(0, 1'b0, 8'h11);
      push(0, 1'b1, 8'h22);
      step(); step(); step();
      chk("t2_c3_ack0", 32'(a_ack0), 32'd1);
      chk("t2_c3_rdata", 32'(a_rdata), 32'h11);
      a_req0 = 1'b0;
      step(); step(); step(); step();
      chk("t2_c7_ack1", 32'(a_ack1), 32'd1);
      chk("t2_c7_rdata", 32'(a_rdata), 32'h22);
      a_req1 = 1'b0;
      step();
      chk("t2_c8_busy", 32'(a_busy), 32'd0);

      // Sustained load from both ports: grants alternate, starting with 0
      a_req0 = 1'b1;
      a_req1 = 1'b1;
      for (int t = 0; t < 6; t++) push(0, 1'(t % 2), (t % 2) ? 8'h22 : 8'h11);
      for (int t = 0; t < 6; t++) begin
         wait_a_ack(10);
         chk("rr_grant", 32'(a_grant), 32'(t % 2));
      end
      a_req0 = 1'b0;
      a_req1 = 1'b0;
      step();
      chk("rr_idle", 32'(a_busy), 32'd0);

      // Out of range on instance B (ROM_SIZE = 1)
      b_req1 = 1'b1;
      b_addr1 = 14'h0005;
      push(1, 1'b1, 8'hFF);
      step();
      chk("oor_c1_cs", 32'(b_rom_cs), 32'd0);
      chk("oor_c1_busy", 32'(b_busy), 32'd1);
      step();
      chk("oor_c2_cs", 32'(b_rom_cs), 32'd0);
      step();
      chk("oor_c3_ack1", 32'(b_ack1), 32'd1);
      chk("oor_c3_cs", 32'(b_rom_cs), 32'd0);
      b_req1 = 1'b0;
      step();

      // Reset in the first ACCESS cycle aborts the read without an ack
      a_req0 = 1'b1;
      a_addr0 = 14'h0000;
      step();
      chk("rma_c1_cs", 32'(a_rom_cs), 32'd1);
      reset = 1'b1;
      step();
      chk("rma_cs", 32'(a_rom_cs), 32'd0);
      chk("rma_busy", 32'(a_busy), 32'd0);
      chk("rma_grant", 32'(a_grant), 32'd1);
      reset = 1'b0;
      push(0, 1'b0, 8'h76);
      step();
      chk("rma_n_c1_cs", 32'(a_rom_cs), 32'd1);
      step();
      chk("rma_n_c2_ack", 32'(a_ack0), 32'd0);
      step();
      chk("rma_n_c3_ack0", 32'(a_ack0), 32'd1);
      chk("rma_n_c3_grant", 32'(a_grant), 32'd0);
      a_req0 = 1'b0;
      step();

      // Zero wait states on instance C
      c_req0 = 1'b1;
      c_addr0 = 14'h0003;
      push(2, 1'b0, 8'hA5);
      step();
      chk("ws0_c1_cs", 32'(c_rom_cs), 32'd1);
      step();
      chk("ws0_c2_cs", 32'(c_rom_cs), 32'd0);
      chk("ws0_c2_ack0", 32'(c_ack0), 32'd1);
      chk("ws0_c2_rdata", 32'(c_rdata), 32'hA5);
      c_req0 = 1'b0;
      step();
      chk("ws0_c3_busy", 32'(c_busy), 32'd0);

      step();
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
